// File: rtl/prog_counter.sv
// Parametrised GPIO counter: prescaled up/down stepping with wrap or
// saturate, synchronous load, compare match and pad output-enable.
module prog_counter #(
    parameter int WIDTH = 16,
    parameter int PS_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [PS_W-1:0]  prescale,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             cmp_hit,
    output logic             ovf,
    output logic [WIDTH-1:0] io_oeb
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [PS_W-1:0]  ps_cnt;
    logic             tick;
    logic             at_edge;
    logic [WIDTH-1:0] nxt;

    assign tick    = en && (ps_cnt == prescale);
    assign at_edge = up_dn ? (count == MAX) : (count == '0);
    assign nxt     = up_dn ? count + 1'b1 : count - 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            tc      <= 1'b0;
            cmp_hit <= 1'b0;
            ovf     <= 1'b0;
            ps_cnt  <= '0;
            io_oeb  <= '1;
        end else begin
            io_oeb  <= '0;
            tc      <= 1'b0;
            cmp_hit <= 1'b0;
            if (load) begin
                count   <= load_val;
                ps_cnt  <= '0;
                ovf     <= 1'b0;
                cmp_hit <= (load_val == cmp_val);
            end else if (tick) begin
                ps_cnt <= '0;
                if (at_edge) begin
                    tc  <= 1'b1;
                    ovf <= 1'b1;
                end
                // A saturated hold is not an update, so it never fires cmp_hit.
                if (!(at_edge && sat_en)) begin
                    count   <= nxt;
                    cmp_hit <= (nxt == cmp_val);
                end
            end else if (en) begin
                ps_cnt <= ps_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter with an arithmetic reference
// model and directed plus randomized scenarios.
module tb_prog_counter;

    logic        clk;
    logic        reset;
    logic        en;
    logic        up_dn;
    logic        sat_en;
    logic        load;
    logic [15:0] load_val;
    logic [7:0]  prescale;
    logic [15:0] cmp_val;
    logic [15:0] count;
    logic        tc;
    logic        cmp_hit;
    logic        ovf;
    logic [15:0] io_oeb;

    int n_vec;
    int n_err;

    // reference state
    int unsigned m_count;
    int unsigned m_ps;
    bit          m_tc;
    bit          m_hit;
    bit          m_ovf;
    bit          m_oeb;

    localparam int unsigned MOD  = 65536;
    localparam int unsigned MAXV = 65535;

    prog_counter #(.WIDTH(16), .PS_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn),
        .sat_en(sat_en), .load(load), .load_val(load_val),
        .prescale(prescale), .cmp_val(cmp_val), .count(count),
        .tc(tc), .cmp_hit(cmp_hit), .ovf(ovf), .io_oeb(io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_count = 0;
        m_ps    = 0;
        m_tc    = 0;
        m_hit   = 0;
        m_ovf   = 0;
        m_oeb   = 1;
    endtask

    // One clock of the counter rules, computed from the current inputs.
    task automatic model_clock();
        int unsigned target;
        bit          edge_hit;
        m_tc  = 0;
        m_hit = 0;
        m_oeb = 0;
        if (load) begin
            m_count = int'(load_val);
            m_ps    = 0;
            m_ovf   = 0;
            m_hit   = (m_count == int'(cmp_val));
        end else if (en) begin
            if (m_ps == int'(prescale)) begin
                m_ps = 0;
                if (up_dn) begin
                    edge_hit = (m_count == MAXV);
                    target   = (m_count + 1) % MOD;
                end else begin
                    edge_hit = (m_count == 0);
                    target   = (m_count + MOD - 1) % MOD;
                end
                if (edge_hit) begin
                    m_tc  = 1;
                    m_ovf = 1;
                end
                if (!(edge_hit && sat_en)) begin
                    m_count = target;
                    m_hit   = (target == int'(cmp_val));
                end
            end else begin
                m_ps = (m_ps + 1) % 256;
            end
        end
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en       = 0;
        up_dn    = 1;
        sat_en   = 0;
        load     = 0;
        load_val = 0;
        prescale = 0;
        cmp_val  = 16'hAAAA;
    endtask

    task automatic do_load(input logic [15:0] v);
        load     = 1;
        load_val = v;
        step();
        load = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        #1 reset = 0;
        model_reset();
        #2;
        n_vec++;
        if (count !== 16'h0 || tc !== 0 || ovf !== 0 ||
            cmp_hit !== 0 || io_oeb !== 16'hFFFF) begin
            n_err++;
            $display("FAIL reset_hold count=%h tc=%b ovf=%b hit=%b oeb=%h want 0000 0 0 0 FFFF",
                     count, tc, ovf, cmp_hit, io_oeb);
        end
        @(posedge clk);
        #1;
        reset = 1;
        step();
        n_vec++;
        if (io_oeb !== 16'h0000 || count !== 16'h0) begin
            n_err++;
            $display("FAIL oeb_release oeb=%h count=%h want 0000 0000", io_oeb, count);
        end
        do_load(16'h0005);
        n_vec++;
        if (count !== 16'h0005) begin
            n_err++;
            $display("FAIL reset_preload count=%h want 0005", count);
        end
        #2 reset = 0;
        model_reset();
        #1;
        n_vec++;
        if (count !== 16'h0 || io_oeb !== 16'hFFFF) begin
            n_err++;
            $display("FAIL async_reset count=%h oeb=%h want 0000 FFFF", count, io_oeb);
        end
        @(posedge clk);
        #1;
        reset = 1;
        step();
    endtask

    task automatic test_prescale();
        idle();
        prescale = 3;
        en       = 1;
        do_load(16'h0000);
        for (int i = 0; i < 15; i++) begin
            step();
            n_vec++;
            if (count !== 16'(m_count)) begin
                n_err++;
                $display("FAIL prescale_cyc%0d count=%h want %h", i, count, 16'(m_count));
            end
        end
        n_vec++;
        if (count !== 16'h0003) begin
            n_err++;
            $display("FAIL prescale_16 count=%h want 0003", count);
        end
        en = 0;
        for (int i = 0; i < 5; i++) step();
        n_vec++;
        if (count !== 16'h0003) begin
            n_err++;
            $display("FAIL en_freeze count=%h want 0003", count);
        end
        en = 1;
        step();
        n_vec++;
        if (count !== 16'h0004 || count !== 16'(m_count)) begin
            n_err++;
            $display("FAIL ps_frozen count=%h want 0004", count);
        end
    endtask

    task automatic test_wrap_sat();
        idle();
        en = 1;
        do_load(16'hFFFE);
        step();
        n_vec++;
        if (count !== 16'hFFFF || tc !== 0) begin
            n_err++;
            $display("FAIL wrap_ffff count=%h tc=%b want FFFF 0", count, tc);
        end
        step();
        n_vec++;
        if (count !== 16'h0000 || tc !== 1 || ovf !== 1) begin
            n_err++;
            $display("FAIL wrap_0000 count=%h tc=%b ovf=%b want 0000 1 1", count, tc, ovf);
        end
        step();
        n_vec++;
        if (tc !== 0 || ovf !== 1 || count !== 16'h0001) begin
            n_err++;
            $display("FAIL wrap_after count=%h tc=%b ovf=%b want 0001 0 1", count, tc, ovf);
        end
        sat_en = 1;
        do_load(16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (count !== 16'hFFFF || tc !== (i > 0) || tc !== m_tc) begin
                n_err++;
                $display("FAIL sat_up%0d count=%h tc=%b want FFFF %b", i, count, tc, i > 0);
            end
        end
    endtask

    task automatic test_down();
        idle();
        en    = 1;
        up_dn = 0;
        do_load(16'h0001);
        step();
        n_vec++;
        if (count !== 16'h0000 || tc !== 0) begin
            n_err++;
            $display("FAIL down_0000 count=%h tc=%b want 0000 0", count, tc);
        end
        step();
        n_vec++;
        if (count !== 16'hFFFF || tc !== 1 || ovf !== 1) begin
            n_err++;
            $display("FAIL down_wrap count=%h tc=%b ovf=%b want FFFF 1 1", count, tc, ovf);
        end
        sat_en = 1;
        do_load(16'h0001);
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (count !== 16'h0000 || tc !== (i > 0)) begin
                n_err++;
                $display("FAIL sat_dn%0d count=%h tc=%b want 0000 %b", i, count, tc, i > 0);
            end
        end
    endtask

    task automatic test_load_priority();
        idle();
        en     = 1;
        sat_en = 1;
        do_load(16'hFFFF);
        step();
        n_vec++;
        if (ovf !== 1 || count !== 16'hFFFF) begin
            n_err++;
            $display("FAIL lp_setup count=%h ovf=%b want FFFF 1", count, ovf);
        end
        prescale = 2;
        step();
        step();
        load     = 1;
        load_val = 16'h1234;
        step();
        load = 0;
        n_vec++;
        if (count !== 16'h1234 || tc !== 0 || ovf !== 0) begin
            n_err++;
            $display("FAIL load_prio count=%h tc=%b ovf=%b want 1234 0 0", count, tc, ovf);
        end
        step();
        step();
        n_vec++;
        if (count !== 16'h1234) begin
            n_err++;
            $display("FAIL ps_restart_early count=%h want 1234", count);
        end
        step();
        n_vec++;
        if (count !== 16'h1235) begin
            n_err++;
            $display("FAIL ps_restart count=%h want 1235", count);
        end
    endtask

    task automatic test_compare();
        logic [2:0] hits;
        idle();
        en      = 1;
        cmp_val = 16'h0010;
        do_load(16'h000E);
        for (int i = 0; i < 3; i++) begin
            step();
            hits[i] = cmp_hit;
        end
        n_vec++;
        if (hits !== 3'b010 || count !== 16'h0011) begin
            n_err++;
            $display("FAIL cmp_single hits=%b count=%h want 010 0011", hits, count);
        end
        do_load(16'h0010);
        n_vec++;
        if (cmp_hit !== 1) begin
            n_err++;
            $display("FAIL cmp_load hit=%b want 1", cmp_hit);
        end
        en = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            hits[i] = cmp_hit;
        end
        n_vec++;
        if (hits !== 3'b000 || count !== 16'h0010) begin
            n_err++;
            $display("FAIL cmp_hold hits=%b count=%h want 000 0010", hits, count);
        end
    endtask

    task automatic test_random();
        logic [19:0] got;
        logic [19:0] exp;
        idle();
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            up_dn    = ($urandom_range(0, 7) != 0) ? up_dn : ~up_dn;
            sat_en   = ($urandom_range(0, 15) != 0) ? sat_en : ~sat_en;
            load     = ($urandom_range(0, 19) == 0);
            load_val = ($urandom_range(0, 1) != 0) ? 16'($urandom) :
                       16'($urandom_range(0, 3) + 16'hFFFC);
            prescale = 8'($urandom_range(0, 2));
            cmp_val  = ($urandom_range(0, 3) == 0) ? 16'($urandom) :
                       16'(m_count + $urandom_range(0, 2));
            step();
            got = {count, tc, cmp_hit, ovf, io_oeb[0]};
            exp = {16'(m_count), m_tc, m_hit, m_ovf, m_oeb};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL rand%0d {count,tc,hit,ovf,oeb}=%h want %h", i, got, exp);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle();
        test_reset();
        test_prescale();
        test_wrap_sat();
        test_down();
        test_load_priority();
        test_compare();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
Parametrised successor to the fixed 16-bit GPIO counter in the user project area. Configurable width, runtime-selectable up/down direction, wrap or saturate mode, clock prescaler, synchronous load and a compare-match output. Instantiated in user_project_wrapper, with `count` driven onto a contiguous io_out slice and `io_oeb` onto the matching io_oeb slice.

Parameters:
WIDTH, 16, counter width in bits (2..32).
PS_W, 8, prescaler register width in bits (1..16).

Ports:
clk  input  1  system clock (wb_clk_i at wrapper level).
reset  input  1  asynchronous active-low reset; 0 = reset asserted.
en  input  1  count enable; gates the prescaler and stepping.
up_dn  input  1  direction: 1 = up, 0 = down.
sat_en  input  1  1 = saturate at boundary, 0 = wrap.
load  input  1  synchronous load strobe.
load_val  input  WIDTH  value written to count on load.
prescale  input  PS_W  step every prescale+1 enabled cycles.
cmp_val  input  WIDTH  compare value.
count  output  WIDTH  current counter value (registered).
tc  output  1  terminal-count pulse (registered, 1 cycle).
cmp_hit  output  1  compare-match pulse (registered, 1 cycle).
ovf  output  1  sticky boundary flag, cleared by load or reset.
io_oeb  output  WIDTH  pad output-enable bar for count pins.

Behaviour:
- Reset asserted (async, any time): count=0, tc=0, cmp_hit=0, ovf=0, prescaler=0, io_oeb=all 1s (pads tristated). Values take effect immediately on assertion, not at the next clock edge.
- First rising clk edge after reset deasserts: io_oeb = all 0s. io_oeb stays 0 until the next reset.
- Prescaler ps_cnt (PS_W bits):
  - en=1 and ps_cnt==prescale: tick=1, ps_cnt<=0.
  - en=1 otherwise: ps_cnt<=ps_cnt+1.
  - en=0: ps_cnt holds, no tick.
  - prescale=0: tick on every enabled cycle.
  - prescale lowered below the current ps_cnt: ps_cnt keeps incrementing and wraps at 2^PS_W, then matches. This is accepted behaviour.
- Priority per cycle: load > tick > hold.
- load=1:
  - count<=load_val, ps_cnt<=0, ovf<=0, tc<=0.
  - Load applies even when en=0.
  - Any tick in the same cycle is discarded.
- Tick, up, count<MAX (MAX = 2^WIDTH-1): count<=count+1.
- Tick, up, count==MAX:
  - wrap mode: count<=0.
  - saturate mode: count holds MAX.
  - Both modes: tc<=1, ovf<=1.
- Tick, down, count>0: count<=count-1.
- Tick, down, count==0:
  - wrap mode: count<=MAX.
  - saturate mode: count holds 0.
  - Both modes: tc<=1, ovf<=1.
- Saturate mode: tc pulses on every tick taken at the boundary, not only the first.
- tc is 0 in every cycle without a boundary tick.
- cmp_hit<=1 in the cycle count is updated by a tick or load whose new value equals cmp_val. Otherwise 0.
  - A count held at cmp_val by en=0 or by saturation does not re-fire, because no update occurs.
  - Saturate-mode hold at a boundary that equals cmp_val does not fire.
- up_dn, sat_en, cmp_val and prescale are sampled every cycle. A direction or mode change takes effect on the next tick, with no restart.
- Latency: count, tc and cmp_hit update on the clk edge where tick/load is evaluated (1 cycle from input).
- All arithmetic is modulo 2^WIDTH. No combinational path from inputs to outputs.

Test Plan:
- Reset/oeb: hold reset=0, then release. Required: count=0, tc=0, ovf=0, io_oeb=FFFF during reset; io_oeb=0000 one edge after release. Then assert reset mid-count at count=0x0005: count=0 immediately, without waiting for clk.
- Prescaled up-count: WIDTH=16, prescale=3, en=1, up. Required: count increments once every 4 cycles, reaching 0x0003 after 16 enabled cycles. Holding en=0 for 5 cycles freezes both count and ps_cnt.
- Wrap/saturate up: load 0xFFFE, prescale=0. Wrap mode: sequence FFFF, 0000; tc pulses once on the 0000 transition; ovf=1. Saturate mode: FFFF, FFFF, FFFF; tc=1 on both boundary ticks.
- Down boundary: load 0x0001, down, wrap mode. Required: 0000 then FFFF with a tc pulse. Repeat in saturate mode: holds 0000 with tc each tick.
- Load priority: load=1 with tick active and count=FFFF. Required: count=load_val=0x1234, no tc, ovf cleared, ps_cnt restarts (next tick after prescale+1 cycles).
- Compare: cmp_val=0x0010, count up from 0x000E. Required: cmp_hit a single cycle with count=0x0010. Loading 0x0010 fires cmp_hit again. Then en=0 at 0x0010: no further pulses.
